serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 12 +
 rtl/serial_add_ctrl_if.sv | 27 ++
 rtl/serial_add_ctrl_fulladd.sv | 13 +
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_serial_add_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester and the serial adder.
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_fulladd.sv
// Single-bit full adder; the only arithmetic in the serial adder.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ cin;
  assign carry_out = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder stepped LSB first, with a
// carry flop closing the loop between cycles.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_nx;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             load;
  logic             step;
  logic             last;
  logic             fa_sum;
  logic             fa_co;

  fulladd u_fa (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .cin       (carry_q),
    .sum       (fa_sum),
    .carry_out (fa_co)
  );

  // The final step's bit must land in the result, so the copy to sum uses
  // the shift register's next value rather than its current one.
  assign sum_nx = {fa_sum, sum_sr[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          last    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand shift registers, carry flop, bit counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      if (load) begin
        a_sr    <= bus.a;
        b_sr    <= bus.b;
        carry_q <= bus.cin;
        cnt_q   <= '0;
      end else if (step) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        sum_sr  <= sum_nx;
        carry_q <= fa_co;
        cnt_q   <= cnt_q + CW'(1);
      end
      if (last) begin
        sum_q  <= sum_nx;
        cout_q <= fa_co;
      end
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n8;
  logic rst_n4;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(4)) bus4 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n8), .bus(bus8));
  serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n4), .bus(bus4));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  int         bc8 = 0;
  int         bc4 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // WIDTH=8 monitor: counts busy cycles, pops expected result on done.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n8) bc8 = 0;
    else begin
      if (bus8.busy) bc8++;
      if (bus8.busy && bus8.done) check("busy_done_excl8", 1, 0);
      if (bus8.done) begin
        check("busy_len8", bc8, 8);
        bc8 = 0;
        if (q8.size() == 0) check("unexpected_done8", 1, 0);
        else begin
          e = q8.pop_front();
          check("sum8", bus8.sum, e[7:0]);
          check("cout8", bus8.cout, e[8]);
        end
      end
    end
  end

  // WIDTH=4 monitor.
  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst_n4) bc4 = 0;
    else begin
      if (bus4.busy) bc4++;
      if (bus4.busy && bus4.done) check("busy_done_excl4", 1, 0);
      if (bus4.done) begin
        check("busy_len4", bc4, 4);
        bc4 = 0;
        if (q4.size() == 0) check("unexpected_done4", 1, 0);
        else begin
          e = q4.pop_front();
          check("sum4", bus4.sum, e[3:0]);
          check("cout4", bus4.cout, e[4]);
        end
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic c, input bit push);
    bus8.a     = av;
    bus8.b     = bv;
    bus8.cin   = c;
    bus8.start = 1'b1;
    if (push) q8.push_back({1'b0, av} + {1'b0, bv} + 9'(c));
    @(negedge clk);
    bus8.start = 1'b0;
    check("accept8", bus8.busy, 1);
  endtask

  task automatic start4(input logic [3:0] av, input logic [3:0] bv, input logic c);
    bus4.a     = av;
    bus4.b     = bv;
    bus4.cin   = c;
    bus4.start = 1'b1;
    q4.push_back({1'b0, av} + {1'b0, bv} + 5'(c));
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  // k0 = negedges already elapsed since the accept edge.
  task automatic wait8(input int k0);
    int k = k0;
    while (!bus8.done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!bus8.done) check("timeout8", 0, 1);
    else            check("latency8", k, 9);
  endtask

  task automatic wait4();
    int k = 1;
    while (!bus4.done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!bus4.done) check("timeout4", 0, 1);
    else            check("latency4", k, 5);
  endtask

  initial begin
    clk        = 1'b0;
    rst_n8     = 1'b0;
    rst_n4     = 1'b0;
    bus8.start = 1'b1;
    bus8.a     = 8'h3C;
    bus8.b     = 8'h42;
    bus8.cin   = 1'b0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    bus4.cin   = 1'b0;

    // Reset held with start asserted.
    repeat (2) @(negedge clk);
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_sum", bus8.sum, 8'h00);
    check("rst_cout", bus8.cout, 0);
    check("rst_sum4", bus4.sum, 4'h0);

    // Release reset with start still high: accepted on the first edge.
    q8.push_back(9'h07E);
    rst_n8 = 1'b1;
    rst_n4 = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    check("accept_after_rst", bus8.busy, 1);
    wait8(1);

    // Carry propagation cases.
    @(negedge clk);
    start8(8'hFF, 8'h01, 1'b0, 1'b1);
    wait8(1);
    @(negedge clk);
    start8(8'hA5, 8'h5A, 1'b1, 1'b1);
    wait8(1);

    // Start during RUN and during DONE is ignored.
    @(negedge clk);
    start8(8'h3C, 8'h42, 1'b0, 1'b1);
    bus8.a     = 8'h11;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait8(2);
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (12) @(negedge clk);
    check("idle_after_done", bus8.busy, 0);

    // Reset in the 4th RUN cycle aborts with no done.
    start8(8'h3C, 8'h42, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n8 = 1'b0;
    #1;
    check("abort_busy", bus8.busy, 0);
    check("abort_done", bus8.done, 0);
    check("abort_sum", bus8.sum, 8'h00);
    check("abort_cout", bus8.cout, 0);
    @(negedge clk);
    rst_n8 = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", bus8.done, 0);
    start8(8'h81, 8'h7F, 1'b1, 1'b1);
    wait8(1);

    // Exhaustive WIDTH=4.
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          @(negedge clk);
          start4(4'(ai), 4'(bi), 1'(ci));
          wait4();
        end

    repeat (4) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q4_drained", q4.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
